// File: rtl/overlay_pkg.sv
// overlay_pkg: shared geometry constants, controller state and bounce helper
package overlay_pkg;
  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
  localparam int HALF = 64;
  localparam int STEP = 8;
  localparam int ROW_MIN = HALF - 1;
  localparam int ROW_MAX = V_ACTIVE - HALF - 1;
  localparam int COL_MIN = HALF - 1;
  localparam int COL_MAX = H_ACTIVE - HALF - 1;
  localparam logic [9:0] RST_ROW = 10'd300;
  localparam logic [9:0] RST_COL = 10'd400;
  typedef enum logic {S_OFF, S_RUN} ctrl_state_t;
  typedef struct packed {
    logic [9:0] pos;
    logic tog;
  } step_t;
  function automatic step_t bounce_step(logic [9:0] pos, logic dir, int lo, int hi);
    logic signed [11:0] n;
    n = $signed({2'b00, pos}) + (dir ? -12'(STEP) : 12'(STEP));
    if (!dir && n >= 12'(hi)) return '{pos: 10'(hi), tog: 1'b1};
    if (dir && n <= 12'(lo)) return '{pos: 10'(lo), tog: 1'b1};
    return '{pos: n[9:0], tog: 1'b0};
  endfunction
endpackage

// File: rtl/overlay_clamp.sv
// overlay_clamp: clamps a signed 12-bit coordinate into [LO, HI] as 10 bits
module overlay_clamp #(
  parameter int LO = 0,
  parameter int HI = 1023
) (
  input  logic signed [11:0] val,
  output logic [9:0]         q
);
  localparam logic signed [11:0] LO_S = 12'(LO);
  localparam logic signed [11:0] HI_S = 12'(HI);
  // saturate at either bound, otherwise pass the low bits through
  always_comb q = val < LO_S ? 10'(LO) : val > HI_S ? 10'(HI) : val[9:0];
endmodule

// File: rtl/overlay_ctrl.sv
// overlay_ctrl: frame-synchronous position/enable control for the highlight box
module overlay_ctrl
  import overlay_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_start,
  input  logic       i_enable,
  input  logic       i_bounce,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [9:0] i_req_row,
  input  logic [9:0] i_req_col,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  output logic [9:0] o_row,
  output logic [9:0] o_col,
  output logic       o_enable,
  output logic       o_commit
);
  localparam logic signed [11:0] STP = 12'(STEP);
  ctrl_state_t state_q, state_d;
  logic [9:0] pend_r, pend_c, cl_r, cl_c, disp_r, disp_c;
  logic abs_pend, dir_r, dir_c, hs, nud, commit, bnc;
  logic signed [11:0] dr, dc, cin_r, cin_c;
  step_t st_r, st_c;

  assign hs = i_req_valid && !abs_pend;
  assign nud = !i_bounce && (i_up || i_down || i_left || i_right);
  assign commit = i_frame_start && i_enable;
  assign bnc = commit && state_q == S_RUN && i_bounce && !abs_pend;
  assign dr = (i_down ? STP : 12'sd0) - (i_up ? STP : 12'sd0);
  assign dc = (i_right ? STP : 12'sd0) - (i_left ? STP : 12'sd0);
  assign cin_r = hs ? $signed({2'b00, i_req_row}) : $signed({2'b00, pend_r}) + dr;
  assign cin_c = hs ? $signed({2'b00, i_req_col}) : $signed({2'b00, pend_c}) + dc;
  assign st_r = bounce_step(pend_r, dir_r, ROW_MIN, ROW_MAX);
  assign st_c = bounce_step(pend_c, dir_c, COL_MIN, COL_MAX);
  assign disp_r = bnc ? st_r.pos : pend_r;
  assign disp_c = bnc ? st_c.pos : pend_c;
  assign o_enable = state_q == S_RUN;
  assign o_req_ready = !abs_pend;

  overlay_clamp #(.LO(ROW_MIN), .HI(ROW_MAX)) u_clamp_r (.val(cin_r), .q(cl_r));
  overlay_clamp #(.LO(COL_MIN), .HI(COL_MAX)) u_clamp_c (.val(cin_c), .q(cl_c));

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state_q <= S_OFF;
    else state_q <= state_d;

  // on/off decision is sampled only at frame start
  always_comb begin
    state_d = state_q;
    if (i_frame_start) state_d = i_enable ? S_RUN : S_OFF;
  end

  // pending/committed position, request flag and bounce direction
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      pend_r <= RST_ROW;
      pend_c <= RST_COL;
      o_row <= RST_ROW;
      o_col <= RST_COL;
      abs_pend <= 1'b0;
      dir_r <= 1'b0;
      dir_c <= 1'b0;
      o_commit <= 1'b0;
    end else begin
      o_commit <= commit;
      if (commit) begin
        o_row <= disp_r;
        o_col <= disp_c;
      end
      pend_r <= (hs || nud) ? cl_r : commit ? disp_r : pend_r;
      pend_c <= (hs || nud) ? cl_c : commit ? disp_c : pend_c;
      abs_pend <= hs ? 1'b1 : i_frame_start ? 1'b0 : abs_pend;
      if (bnc) begin
        dir_r <= dir_r ^ st_r.tog;
        dir_c <= dir_c ^ st_c.tog;
      end
    end
endmodule

// File: tb/tb_overlay_ctrl.sv
// tb_overlay_ctrl: directed and random checks against a behavioural model
module tb_overlay_ctrl;
  import overlay_pkg::*;
  logic clk = 0, rst_n = 0, fs = 0, en = 0, bnc = 0, vld = 0;
  logic up = 0, dn = 0, lf = 0, rt = 0;
  logic [9:0] rq_r = 0, rq_c = 0;
  logic rdy, o_en, o_cm;
  logic [9:0] o_row, o_col;
  int n_tests = 0, n_fail = 0;
  int m_pr, m_pc, m_row, m_col, m_dr, m_dc;
  bit m_on, m_absp, m_cm;

  overlay_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(fs), .i_enable(en), .i_bounce(bnc),
    .i_req_valid(vld), .o_req_ready(rdy), .i_req_row(rq_r), .i_req_col(rq_c),
    .i_up(up), .i_down(dn), .i_left(lf), .i_right(rt),
    .o_row(o_row), .o_col(o_col), .o_enable(o_en), .o_commit(o_cm)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampi(int v, int lo, int hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction

  task automatic model_reset();
    m_pr = 300; m_pc = 400; m_row = 300; m_col = 400;
    m_dr = 0; m_dc = 0; m_on = 0; m_absp = 0; m_cm = 0;
  endtask

  // bounce one axis: move by STEP, stop at the bound and reverse there
  task automatic bounce_axis(inout int p, inout int d, input int lo, input int hi);
    p = p + (d != 0 ? -STEP : STEP);
    if (d == 0 && p >= hi) begin p = hi; d = 1; end
    else if (d != 0 && p <= lo) begin p = lo; d = 0; end
  endtask

  // one clock edge of the specified behaviour
  task automatic model_step();
    int p0r, p0c, nr, nc;
    bit hs;
    hs = vld && !m_absp;
    p0r = m_pr; p0c = m_pc; nr = m_pr; nc = m_pc;
    m_cm = fs && en;
    if (m_cm) begin
      if (m_on && bnc && !m_absp) begin
        bounce_axis(nr, m_dr, ROW_MIN, ROW_MAX);
        bounce_axis(nc, m_dc, COL_MIN, COL_MAX);
      end
      m_row = nr; m_col = nc;
      m_pr = nr; m_pc = nc;
    end
    if (hs) begin
      m_pr = clampi(int'(rq_r), ROW_MIN, ROW_MAX);
      m_pc = clampi(int'(rq_c), COL_MIN, COL_MAX);
    end else if (!bnc && (up || dn || lf || rt)) begin
      m_pr = clampi(p0r - STEP * int'(up) + STEP * int'(dn), ROW_MIN, ROW_MAX);
      m_pc = clampi(p0c - STEP * int'(lf) + STEP * int'(rt), COL_MIN, COL_MAX);
    end
    m_absp = hs ? 1'b1 : fs ? 1'b0 : m_absp;
    if (fs) m_on = en;
  endtask

  task automatic check_all(string tag);
    chk({tag, "_row"}, int'(o_row), m_row);
    chk({tag, "_col"}, int'(o_col), m_col);
    chk({tag, "_en"}, int'(o_en), int'(m_on));
    chk({tag, "_commit"}, int'(o_cm), int'(m_cm));
    chk({tag, "_ready"}, int'(rdy), int'(!m_absp));
  endtask

  // apply one cycle of inputs at the falling edge, check after the next rising edge
  task automatic drive(string tag, bit f, bit b, bit v, int r, int c, bit u, bit d, bit l, bit rr);
    fs = f; bnc = b; vld = v; rq_r = 10'(r); rq_c = 10'(c);
    up = u; dn = d; lf = l; rt = rr;
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(string tag, int n);
    for (int i = 0; i < n; i++) drive(tag, 0, bnc, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all("in_reset");
    rst_n = 1;
    @(negedge clk);
    check_all("reset");
    for (int i = 0; i < 3; i++) begin
      drive("off_fs", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle("off_idle", 2);
    end
    chk("off_row_const", int'(o_row), 300);
    chk("off_col_const", int'(o_col), 400);
    en = 1;
    drive("req1", 0, 0, 1, 100, 200, 0, 0, 0, 0);
    chk("req1_ready_low", int'(rdy), 0);
    idle("req1_wait", 3);
    drive("req1_fs", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("req1_row_const", int'(o_row), 100);
    chk("req1_col_const", int'(o_col), 200);
    chk("req1_en_const", int'(o_en), 1);
    chk("req1_cm_const", int'(o_cm), 1);
    chk("req1_ready_back", int'(rdy), 1);
    idle("req1_after", 1);
    drive("clamp_req", 0, 0, 1, 0, 799, 0, 0, 0, 0);
    drive("clamp_fs", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("clamp_row_const", int'(o_row), 63);
    chk("clamp_col_const", int'(o_col), 735);
    for (int i = 0; i < 3; i++) drive("nudge_dn", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive("nudge_lf", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive("nudge_fs", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("nudge_row_const", int'(o_row), 87);
    chk("nudge_col_const", int'(o_col), 727);
    drive("sim_fs", 1, 0, 1, 300, 300, 0, 0, 0, 0);
    chk("sim_keep_row", int'(o_row), 87);
    chk("sim_ready_low", int'(rdy), 0);
    idle("sim_idle", 2);
    drive("sim_fs2", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sim_new_row", int'(o_row), 300);
    chk("sim_new_col", int'(o_col), 300);
    drive("bnc_req", 0, 1, 1, 527, 400, 0, 0, 0, 0);
    drive("bnc_fs0", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("bnc0_row_const", int'(o_row), 527);
    drive("bnc_fs1", 1, 1, 0, 0, 0, 1, 0, 1, 0);
    chk("bnc1_row_const", int'(o_row), 535);
    chk("bnc1_col_const", int'(o_col), 408);
    idle("bnc_idle", 2);
    drive("bnc_fs2", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("bnc2_row_const", int'(o_row), 527);
    chk("bnc2_col_const", int'(o_col), 416);
    drive("rst_req", 0, 0, 1, 150, 150, 0, 0, 0, 0);
    idle("rst_mid", 2);
    #2 rst_n = 0;
    en = 0;
    #1 model_reset();
    check_all("rst_async");
    @(negedge clk);
    rst_n = 1;
    check_all("rst_hold");
    drive("rst_fs_off", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_no_commit", int'(o_cm), 0);
    en = 1;
    drive("rst_fs_on", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_on_row", int'(o_row), 300);
    for (int i = 0; i < 4000; i++) begin
      if (i % 97 == 0) en = ($urandom_range(0, 4) != 0);
      if (i % 211 == 0) bnc = ($urandom_range(0, 1) != 0);
      drive("rnd", $urandom_range(0, 7) == 0, bnc, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1023), $urandom_range(0, 1023),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
